tlm_gse_master: RTL and testbench

//  Parametrised GSE-side telemetry master for the rocket readout link. Generates Cnt_Invload

---
 rtl/apes_tlm_pkg.sv | 28 ++
 rtl/tlm_shift_rx.sv | 42 ++++
 rtl/tlm_gse_master.sv | 194 +++++++++++++++++++
 tb/tb_tlm_gse_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apes_tlm_pkg.sv
// Shared definitions for the GSE telemetry master: FSM encoding and default link geometry.
package apes_tlm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HI,
    ST_LO,
    ST_GAP
  } tlm_state_e;

  localparam int DEF_BITS      = 10;
  localparam int DEF_WORDS     = 52;
  localparam int DEF_HALF_CYC  = 5;
  localparam int DEF_LOAD_CYC  = 5;
  localparam int DEF_GAP_CYC   = 64;
  localparam logic [DEF_BITS-1:0] DEF_SYNC_WORD = 10'h2E5;

  // Largest phase length sets the width of the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tlm_shift_rx.sv
// Serial-to-parallel receiver: shifts Cnt_Data in MSB first on each sample enable and
// flags when a full BITS-wide word has been collected.
module tlm_shift_rx
  import apes_tlm_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            sample_en,
  input  logic            din,
  output logic [BITS-1:0] word,
  output logic            word_complete
);

  localparam int BC_W = $clog2(BITS);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BITS - 1);

  logic [BC_W-1:0] bit_cnt;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      word          <= '0;
      bit_cnt       <= '0;
      word_complete <= 1'b0;
    end else if (clr) begin
      bit_cnt       <= '0;
      word_complete <= 1'b0;
    end else if (sample_en) begin
      word <= {word[BITS-2:0], din};
      if (bit_cnt == BIT_LAST) begin
        bit_cnt       <= '0;
        word_complete <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlm_gse_master.sv
// GSE-side telemetry master: drives Cnt_Invload/Cnt_Gtclk, collects words and frames.
// Optional word-0 sync comparator enabled by defining TLM_SYNC_CHECK_EN.
module tlm_gse_master
  import apes_tlm_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int WORDS    = DEF_WORDS,
  parameter int HALF_CYC = DEF_HALF_CYC,
  parameter int LOAD_CYC = DEF_LOAD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
`ifdef TLM_SYNC_CHECK_EN
  parameter logic [BITS-1:0] SYNC_WORD = BITS'(DEF_SYNC_WORD),
`endif
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             Ext_clk_50mhz,
  input  logic             Gse_reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             Cnt_Data,
  output logic             Cnt_Gtclk,
  output logic             Cnt_Invload,
  output logic             busy,
  output logic [BITS-1:0]  word_data,
  output logic             word_valid,
  output logic [IDX_W-1:0] word_idx,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int PH_MAX = max3(LOAD_CYC, HALF_CYC, GAP_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYC - 1);
  localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(HALF_CYC - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);

  tlm_state_e      state;
  logic [PH_W-1:0] ph_cnt;
  logic [IDX_W-1:0] word_cnt;
  logic            ph_last;
  logic            sample_en;
  logic            word_complete;
  logic            word_end;
  logic [BITS-1:0] rx_word;

  // NOTE: default first so no path through the case leaves ph_last unassigned (no latch).
  always_comb begin
    ph_last = 1'b0;
    case (state)
      ST_LOAD:      ph_last = (ph_cnt == LOAD_LAST);
      ST_HI, ST_LO: ph_last = (ph_cnt == HALF_LAST);
      ST_GAP:       ph_last = (ph_cnt == GAP_LAST);
      default:      ph_last = 1'b0;
    endcase
  end

  // Data is taken on the last HI cycle, just before Gtclk falls and the readout shifts.
  assign sample_en = (state == ST_HI) && ph_last;
  assign word_end  = (state == ST_LO) && ph_last && word_complete;

  tlm_shift_rx #(.BITS(BITS)) u_rx (
    .clk           (Ext_clk_50mhz),
    .rst           (Gse_reset),
    .clr           (state == ST_LOAD),
    .sample_en     (sample_en),
    .din           (Cnt_Data),
    .word          (rx_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge Ext_clk_50mhz) begin
    if (Gse_reset) begin
      state       <= ST_IDLE;
      ph_cnt      <= '0;
      word_cnt    <= '0;
      Cnt_Gtclk   <= 1'b0;
      Cnt_Invload <= 1'b1;
      busy        <= 1'b0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_idx    <= '0;
      frame_done  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        // word_data keeps the last complete word; the partial word is dropped.
        state       <= ST_IDLE;
        ph_cnt      <= '0;
        word_cnt    <= '0;
        Cnt_Gtclk   <= 1'b0;
        Cnt_Invload <= 1'b1;
        busy        <= 1'b0;
        word_idx    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state       <= ST_LOAD;
              ph_cnt      <= '0;
              word_cnt    <= '0;
              Cnt_Invload <= 1'b0;
              busy        <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (ph_last) begin
              state       <= ST_HI;
              ph_cnt      <= '0;
              Cnt_Invload <= 1'b1;
              Cnt_Gtclk   <= 1'b1;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
          ST_HI: begin
            if (ph_last) begin
              state     <= ST_LO;
              ph_cnt    <= '0;
              Cnt_Gtclk <= 1'b0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
          ST_LO: begin
            if (!ph_last) begin
              ph_cnt <= ph_cnt + 1'b1;
            end else if (!word_complete) begin
              state     <= ST_HI;
              ph_cnt    <= '0;
              Cnt_Gtclk <= 1'b1;
            end else begin
              ph_cnt     <= '0;
              word_valid <= 1'b1;
              word_data  <= rx_word;
              word_idx   <= word_cnt;
              if (word_cnt != WORD_LAST) begin
                word_cnt    <= word_cnt + 1'b1;
                state       <= ST_LOAD;
                Cnt_Invload <= 1'b0;
              end else begin
                word_cnt   <= '0;
                frame_done <= 1'b1;
                if (!continuous) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else if (GAP_CYC == 0) begin
                  state       <= ST_LOAD;
                  Cnt_Invload <= 1'b0;
                end else begin
                  state <= ST_GAP;
                end
              end
            end
          end
          ST_GAP: begin
            if (ph_last) begin
              state       <= ST_LOAD;
              ph_cnt      <= '0;
              Cnt_Invload <= 1'b0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
          default: begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            Cnt_Gtclk   <= 1'b0;
            Cnt_Invload <= 1'b1;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TLM_SYNC_CHECK_EN
  // Sticky until reset or an accepted start; only word 0 of each frame is compared.
  always_ff @(posedge Ext_clk_50mhz) begin
    if (Gse_reset) begin
      sync_err <= 1'b0;
    end else if ((state == ST_IDLE) && start && !abort) begin
      sync_err <= 1'b0;
    end else if (word_end && !abort && (word_cnt == '0) && (rx_word != SYNC_WORD)) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tlm_gse_master.sv
// Self-checking bench for tlm_gse_master: readout model, waveform monitor, table of frame
// vectors, plus directed continuous/abort/reset sequences.
`timescale 1ns/1ps
module tb_tlm_gse_master;

  localparam int BITS      = 10;
  localparam int WORDS     = 52;
  localparam int HALF      = 5;
  localparam int LOADC     = 5;
  localparam int GAP       = 64;
  localparam int WORD_CYC  = 105;         // 5 + 2*5*10
  localparam int FRAME_CYC = 52 * 105;    // 5460
`ifdef TLM_SYNC_CHECK_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, continuous, abort, cnt_data;
  logic       gtclk, invload, busy, word_valid, frame_done, sync_err;
  logic [9:0] word_data;
  logic [5:0] word_idx;

  tlm_gse_master #(
    .BITS(BITS), .WORDS(WORDS), .HALF_CYC(HALF), .LOAD_CYC(LOADC), .GAP_CYC(GAP)
  ) dut (
    .Ext_clk_50mhz (clk),
    .Gse_reset     (rst),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .Cnt_Data      (cnt_data),
    .Cnt_Gtclk     (gtclk),
    .Cnt_Invload   (invload),
    .busy          (busy),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_idx      (word_idx),
    .frame_done    (frame_done),
    .sync_err      (sync_err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor / readout model state (written only by the monitor block).
  int cyc = 0;
  int epoch = 0, seen_epoch = 0;
  int wv_cnt = 0, fd_cnt = 0, idx_err = 0, data_err = 0, fd_err = 0, pulse_err = 0, overlap_err = 0;
  int exp_idx = 0, ld_idx = 0, bitpos = 0, pulses = 0, last_rise = 0;
  int inv_run = 0, inv_min = 1000, inv_max = 0;
  int hi_run = 0, hi_min = 1000, hi_max = 0;
  int per_min = 1000, per_max = 0;
  logic prev_inv = 1'b1, prev_gt = 1'b0;
  logic [9:0] tx = '0;
  logic [9:0] first_word = '0, other_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      wv_cnt = 0; fd_cnt = 0; idx_err = 0; data_err = 0; fd_err = 0; pulse_err = 0;
      overlap_err = 0; exp_idx = 0; ld_idx = 0; pulses = 0;
      inv_run = 0; inv_min = 1000; inv_max = 0;
      hi_run = 0; hi_min = 1000; hi_max = 0; per_min = 1000; per_max = 0;
    end
    // Readout: load on Invload fall, present MSB, shift on every Gtclk fall.
    if (!invload && prev_inv) begin
      tx = (ld_idx == 0) ? first_word : other_word;
      bitpos = BITS - 1;
      ld_idx = (ld_idx + 1) % WORDS;
    end else if (prev_gt && !gtclk && bitpos > 0) begin
      bitpos--;
    end
    cnt_data = tx[bitpos];

    if (!invload) inv_run++;
    else if (!prev_inv) begin
      if (inv_run < inv_min) inv_min = inv_run;
      if (inv_run > inv_max) inv_max = inv_run;
      inv_run = 0;
    end
    if (gtclk) hi_run++;
    else if (prev_gt) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    if (gtclk && !prev_gt) begin
      if (pulses > 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      pulses++;
    end
    if (gtclk && !invload) overlap_err++;

    if (word_valid) begin
      if (word_idx != 6'(exp_idx)) idx_err++;
      if (word_data != ((exp_idx == 0) ? first_word : other_word)) data_err++;
      if (pulses != BITS) pulse_err++;
      pulses = 0;
      if (frame_done) begin
        fd_cnt++;
        if (word_idx != 6'(WORDS - 1)) fd_err++;
      end
      exp_idx = (exp_idx + 1) % WORDS;
      wv_cnt++;
    end else if (frame_done) begin
      fd_err++;
    end
    prev_inv = invload;
    prev_gt  = gtclk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return !invload;
      1:       return frame_done;
      2:       return word_valid;
      default: return gtclk;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int budget, input string name);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_in_time"}, 32'(cond(sel)), 1);
  endtask

  task automatic wait_word(input int k, input int budget, input string name);
    int n = 0;
    while (!(word_valid && word_idx == 6'(k)) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_in_time"}, 32'(word_valid && word_idx == 6'(k)), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gtclk"},      32'(gtclk), 0);
    check({tag, "_invload"},    32'(invload), 1);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_word_data"},  32'(word_data), 0);
    check({tag, "_word_valid"}, 32'(word_valid), 0);
    check({tag, "_word_idx"},   32'(word_idx), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_sync_err"},   32'(sync_err), 0);
  endtask

  typedef struct {
    logic [9:0] first;
    logic [9:0] other;
    logic       exp_sync;
  } vec_t;

  vec_t vecs[4];
  int   t0, t1, lows;

  initial begin
    vecs[0] = '{10'h155, 10'h155, SYNC_ON};
    vecs[1] = '{10'h2E5, 10'h2AA, 1'b0};
    vecs[2] = '{10'h000, 10'h3FF, SYNC_ON};
    vecs[3] = '{10'h2E5, 10'h000, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    tick(3);
    check_reset_values("reset");
    rst = 1'b0;
    tick(2);

    // Single frames, one per table entry.
    for (int i = 0; i < 4; i++) begin
      first_word = vecs[i].first;
      other_word = vecs[i].other;
      epoch++;
      tick(2);
      pulse_start();
      t0 = cyc;
      check($sformatf("v%0d_load_entry", i), 32'(invload), 0);
      check($sformatf("v%0d_busy", i), 32'(busy), 1);
      wait_cond(1, FRAME_CYC + 10, $sformatf("v%0d_frame_done", i));
      check($sformatf("v%0d_frame_len", i), cyc - t0, FRAME_CYC);
      check($sformatf("v%0d_last_idx", i), 32'(word_idx), WORDS - 1);
      check($sformatf("v%0d_last_data", i), 32'(word_data), 32'(vecs[i].other));
      tick(1);
      check($sformatf("v%0d_busy_fall", i), 32'(busy), 0);
      check($sformatf("v%0d_wv_cnt", i), wv_cnt, WORDS);
      check($sformatf("v%0d_fd_cnt", i), fd_cnt, 1);
      check($sformatf("v%0d_idx_seq", i), idx_err, 0);
      check($sformatf("v%0d_data", i), data_err, 0);
      check($sformatf("v%0d_fd_idx", i), fd_err, 0);
      check($sformatf("v%0d_pulses_per_word", i), pulse_err, 0);
      check($sformatf("v%0d_overlap", i), overlap_err, 0);
      check($sformatf("v%0d_inv_min", i), inv_min, LOADC);
      check($sformatf("v%0d_inv_max", i), inv_max, LOADC);
      check($sformatf("v%0d_hi_min", i), hi_min, HALF);
      check($sformatf("v%0d_hi_max", i), hi_max, HALF);
      check($sformatf("v%0d_per_min", i), per_min, 2 * HALF);
      check($sformatf("v%0d_per_max", i), per_max, 2 * HALF);
      check($sformatf("v%0d_sync_err", i), 32'(sync_err), 32'(vecs[i].exp_sync));
      tick(50);
      check($sformatf("v%0d_sync_hold", i), 32'(sync_err), 32'(vecs[i].exp_sync));
    end

    // Continuous mode: three frames with 64-cycle gaps, continuous dropped during frame 3.
    first_word = 10'h155;
    other_word = 10'h155;
    epoch++;
    tick(2);
    continuous = 1'b1;
    pulse_start();
    t0 = cyc;
    for (int f = 0; f < 2; f++) begin
      wait_cond(1, FRAME_CYC + 10, $sformatf("cont_f%0d_done", f));
      check($sformatf("cont_f%0d_len", f), cyc - t0, FRAME_CYC);
      check($sformatf("cont_f%0d_busy_gap", f), 32'(busy), 1);
      t1 = cyc;
      wait_cond(0, GAP + 10, $sformatf("cont_f%0d_reload", f));
      check($sformatf("cont_f%0d_gap", f), cyc - t1, GAP);
      t0 = cyc;
    end
    tick(1000);
    continuous = 1'b0;
    wait_cond(1, FRAME_CYC, "cont_f2_done");
    check("cont_f2_len", cyc - t0, FRAME_CYC);
    tick(1);
    check("cont_stop_busy", 32'(busy), 0);
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      if (!invload || busy) lows++;
      tick(1);
    end
    check("cont_stop_idle", lows, 0);
    check("cont_wv_cnt", wv_cnt, 3 * WORDS);
    check("cont_fd_cnt", fd_cnt, 3);
    check("cont_idx_seq", idx_err, 0);

    // Abort during word 20, bit 4 HI phase.
    epoch++;
    tick(2);
    pulse_start();
    wait_word(19, 21 * WORD_CYC, "abort_w19");
    tick(46);
    check("abort_in_hi", 32'(gtclk), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_gtclk", 32'(gtclk), 0);
    check("abort_invload", 32'(invload), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_word_idx", 32'(word_idx), 0);
    check("abort_word_valid", 32'(word_valid), 0);
    check("abort_word_data", 32'(word_data), 32'h155);
    tick(300);
    check("abort_no_more_wv", wv_cnt, 20);
    check("abort_no_fd", fd_cnt, 0);

    // start and abort together in IDLE: stay idle.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(20);
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_invload", 32'(invload), 1);

    // Restart after abort: first word index is 0, latency one word.
    epoch++;
    tick(2);
    pulse_start();
    t0 = cyc;
    wait_cond(2, WORD_CYC + 5, "restart_wv");
    check("restart_latency", cyc - t0, WORD_CYC);
    check("restart_idx", 32'(word_idx), 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);

    // start while busy is ignored; Gse_reset in HI phase returns everything to reset.
    first_word = 10'h000;
    other_word = 10'h155;
    epoch++;
    tick(2);
    pulse_start();
    wait_word(2, 4 * WORD_CYC, "rst_w2");
    t1 = cyc;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_word(3, WORD_CYC + 5, "rst_w3");
    check("busy_start_ignored", cyc - t1, WORD_CYC);
    check("sync_before_rst", 32'(sync_err), 32'(SYNC_ON));
    tick(7);
    check("rst_in_hi", 32'(gtclk), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_values("midrst");
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
